// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared ALU control codes, sequencer state enum, latency limit and counter type
package alu_sequencer_pkg;
  localparam int ALU_LAT_MAX = 3;
  localparam int NCODES = 16;
  typedef enum logic [3:0] {
    ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_NAND, ALU_XNOR, ALU_PASSA, ALU_PASSB, ALU_LUI
  } alu_ctrl_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} seq_state_e;
  typedef logic [$clog2(ALU_LAT_MAX + 1)-1:0] lat_cnt_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: start/busy/done handshake, operands, ALU drive/result and buffer read port (master=host, slave=sequencer)
interface alu_sequencer_if import alu_sequencer_pkg::*; #(parameter int WIDTH = 32);
  logic              start;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [NCODES-1:0] op_mask;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  alu_d1;
  logic [WIDTH-1:0]  alu_d2;
  logic [3:0]        alu_control;
  logic [WIDTH-1:0]  alu_result;
  logic [3:0]        rd_idx;
  logic [WIDTH-1:0]  rd_data;
  logic [NCODES-1:0] valid_mask;
  modport master (
    output start, op_a, op_b, op_mask, alu_result, rd_idx,
    input  busy, done, alu_d1, alu_d2, alu_control, rd_data, valid_mask
  );
  modport slave (
    input  start, op_a, op_b, op_mask, alu_result, rd_idx,
    output busy, done, alu_d1, alu_d2, alu_control, rd_data, valid_mask
  );
endinterface

// File: rtl/alu_seq_rbuf.sv
// alu_seq_rbuf: 16xWIDTH result buffer; ports clk/rst, clr_i, we_i/widx_i/wdata_i write, rd_idx_i -> rd_data_o (registered, read-before-write), valid_o
module alu_seq_rbuf import alu_sequencer_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [3:0]        widx_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [3:0]        rd_idx_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic [NCODES-1:0] valid_o
);
  logic [WIDTH-1:0]  mem_q [NCODES];
  logic [WIDTH-1:0]  rd_q;
  logic [NCODES-1:0] valid_q, valid_d;
  always_comb valid_d = clr_i ? '0 : we_i ? valid_q | (NCODES'(1) << widx_i) : valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCODES; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      valid_q <= '0;
    end else begin
      rd_q    <= mem_q[rd_idx_i];
      valid_q <= valid_d;
      if (we_i) mem_q[widx_i] <= wdata_i;
    end
  end
  assign rd_data_o = rd_q;
  assign valid_o   = valid_q;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sweeps ALU control codes 0..15 over latched operands and captures results; ports clk, rst, bus (alu_sequencer_if.slave)
module alu_sequencer import alu_sequencer_pkg::*; #(
  parameter int ALU_LAT = 0,
  parameter int WIDTH   = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);
  localparam lat_cnt_t LAT = lat_cnt_t'(ALU_LAT);
  seq_state_e        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  lat_cnt_t          cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [NCODES-1:0] mask_q, mask_d;
  logic              we, clr, adv;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    we      = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        a_d     = bus.op_a;
        b_d     = bus.op_b;
        mask_d  = bus.op_mask;
        idx_d   = 4'd0;
        clr     = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        we    = mask_q[idx_q] && LAT == '0;
        adv   = !mask_q[idx_q] || LAT == '0;
        cnt_d = LAT;
        if (!adv) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - lat_cnt_t'(1);
        we    = cnt_q == lat_cnt_t'(1);
        adv   = we;
      end
      S_DONE: state_d = S_IDLE;
    endcase
    if (adv) begin
      state_d = idx_q == 4'd15 ? S_DONE : S_ISSUE;
      idx_d   = idx_q == 4'd15 ? idx_q : idx_q + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
    end
  end
  assign bus.busy        = state_q != S_IDLE;
  assign bus.done        = state_q == S_DONE;
  assign bus.alu_d1      = a_q;
  assign bus.alu_d2      = b_q;
  assign bus.alu_control = idx_q;
  alu_seq_rbuf #(.WIDTH(WIDTH)) u_rbuf (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .we_i     (we),
    .widx_i   (idx_q),
    .wdata_i  (bus.alu_result),
    .rd_idx_i (bus.rd_idx),
    .rd_data_o(bus.rd_data),
    .valid_o  (bus.valid_mask)
  );
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench for a combinational-ALU and a 2-stage-ALU sequencer
module tb_alu_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [15:0] op_mask = '0;
  logic [3:0] rd_idx = '0;
  int checks = 0, passed = 0, dc0 = 0, dc1 = 0;
  logic [31:0] exp_buf [2][16];
  logic [15:0] exp_valid [2];
  int r_cyc, r_err;
  logic [31:0] r_rd2, r_rd3, p1, p2;
  logic r_busy_done, r_post_busy, r_post_done;
  logic done_w, busy_w;
  logic [31:0] d1_w, d2_w, rd_w;
  logic [3:0] ctl_w;
  logic [15:0] valid_w;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(32)) bus0();
  alu_sequencer_if #(.WIDTH(32)) bus1();
  alu_sequencer #(.ALU_LAT(0), .WIDTH(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  alu_sequencer #(.ALU_LAT(2), .WIDTH(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.start = start & ~sel;
  assign bus1.start = start & sel;
  assign bus0.op_a = op_a;
  assign bus1.op_a = op_a;
  assign bus0.op_b = op_b;
  assign bus1.op_b = op_b;
  assign bus0.op_mask = op_mask;
  assign bus1.op_mask = op_mask;
  assign bus0.rd_idx = rd_idx;
  assign bus1.rd_idx = rd_idx;
  assign bus0.alu_result = bus0.alu_d1 + bus0.alu_d2 + 32'(bus0.alu_control);
  assign bus1.alu_result = p2;
  always @(posedge clk) begin
    p1 <= bus1.alu_d1 + bus1.alu_d2 + 32'(bus1.alu_control);
    p2 <= p1;
    if (bus0.done) dc0 <= dc0 + 1;
    if (bus1.done) dc1 <= dc1 + 1;
  end

  assign done_w  = sel ? bus1.done : bus0.done;
  assign busy_w  = sel ? bus1.busy : bus0.busy;
  assign d1_w    = sel ? bus1.alu_d1 : bus0.alu_d1;
  assign d2_w    = sel ? bus1.alu_d2 : bus0.alu_d2;
  assign ctl_w   = sel ? bus1.alu_control : bus0.alu_control;
  assign rd_w    = sel ? bus1.rd_data : bus0.rd_data;
  assign valid_w = sel ? bus1.valid_mask : bus0.valid_mask;

  function automatic int exp_cycles(logic [15:0] m, int lat);
    return 17 + $countones(m) * lat;
  endfunction

  task automatic sweep(input logic [31:0] a, input logic [31:0] b, input logic [15:0] m, input int poke);
    int lat = sel ? 2 : 0;
    logic [3:0] q[$];
    for (int i = 0; i < 16; i++) begin
      q.push_back(4'(i));
      if (m[i]) repeat (lat) q.push_back(4'(i));
    end
    op_a = a;
    op_b = b;
    op_mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r_cyc = 1;
    r_err = 0;
    while (r_cyc < 400 && !done_w) begin
      if (r_cyc <= q.size() && ctl_w !== q[r_cyc-1]) r_err++;
      if (busy_w !== 1'b1 || d1_w !== a || d2_w !== b) r_err++;
      if (r_cyc == 2) r_rd2 = rd_w;
      if (r_cyc == 3) r_rd3 = rd_w;
      if (r_cyc == poke) begin
        start = 1'b1;
        op_a = $urandom;
        op_b = $urandom;
        op_mask = 16'hFFFF;
      end
      if (r_cyc == poke + 3) start = 1'b0;
      @(posedge clk); #1;
      r_cyc++;
    end
    start = 1'b0;
    r_busy_done = busy_w;
    @(posedge clk); #1;
    r_post_busy = busy_w;
    r_post_done = done_w;
    for (int i = 0; i < 16; i++) if (m[i]) exp_buf[sel][i] = a + b + 32'(i);
    exp_valid[sel] = m;
  endtask

  task automatic rd(input int i, output logic [31:0] d);
    rd_idx = 4'(i);
    @(posedge clk); #1;
    d = rd_w;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      checks++;
      if ({busy_w, done_w, d1_w, d2_w, ctl_w, rd_w, valid_w} !== '0)
        $display("FAIL reset_outputs dut%0d: got busy=%b done=%b d1=%h d2=%h ctl=%h rd=%h valid=%h expected all zero",
                 s, busy_w, done_w, d1_w, d2_w, ctl_w, rd_w, valid_w);
      else passed++;
    end
    sel = 1'b0;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      exp_valid[s] = '0;
      for (int i = 0; i < 16; i++) exp_buf[s][i] = '0;
    end
  endtask

  task automatic test_comb;
    logic [31:0] d;
    sel = 1'b0;
    sweep(32'hF31474A1, 32'h5, 16'hFFFF, -1);
    checks++; if (r_cyc !== 17) $display("FAIL comb_done_cycle: got %0d expected 17", r_cyc); else passed++;
    checks++; if (r_busy_done !== 1'b1) $display("FAIL comb_busy_in_done: got %b expected 1", r_busy_done); else passed++;
    checks++; if ({r_post_busy, r_post_done} !== 2'b00) $display("FAIL comb_after_done: got busy=%b done=%b expected 0 0", r_post_busy, r_post_done); else passed++;
    checks++; if (r_err !== 0) $display("FAIL comb_drive: got %0d bad cycles expected 0", r_err); else passed++;
    checks++; if (valid_w !== 16'hFFFF) $display("FAIL comb_valid: got %h expected ffff", valid_w); else passed++;
    rd(3, d);
    checks++; if (d !== 32'hF31474A9) $display("FAIL comb_rd3: got %h expected f31474a9", d); else passed++;
    rd(15, d);
    checks++; if (d !== 32'hF31474B5) $display("FAIL comb_rd15: got %h expected f31474b5", d); else passed++;
    for (int i = 0; i < 16; i++) begin
      rd(i, d);
      checks++; if (d !== exp_buf[0][i]) $display("FAIL comb_entry%0d: got %h expected %h", i, d, exp_buf[0][i]); else passed++;
    end
  endtask

  task automatic test_partial;
    logic [31:0] d, old0;
    sel = 1'b0;
    old0 = exp_buf[0][0];
    rd_idx = 4'd0;
    sweep(32'h0, 32'h0, 16'h8001, -1);
    checks++; if (r_cyc !== 17) $display("FAIL part_done_cycle: got %0d expected 17", r_cyc); else passed++;
    checks++; if (valid_w !== 16'h8001) $display("FAIL part_valid: got %h expected 8001", valid_w); else passed++;
    checks++; if (r_rd2 !== old0) $display("FAIL part_rd_write_same_cycle: got %h expected old %h", r_rd2, old0); else passed++;
    checks++; if (r_rd3 !== 32'h0) $display("FAIL part_rd_after_write: got %h expected 00000000", r_rd3); else passed++;
    rd(0, d);
    checks++; if (d !== 32'h0) $display("FAIL part_rd0: got %h expected 00000000", d); else passed++;
    rd(15, d);
    checks++; if (d !== 32'hF) $display("FAIL part_rd15: got %h expected 0000000f", d); else passed++;
    rd(3, d);
    checks++; if (d !== 32'hF31474A9) $display("FAIL part_rd3_kept: got %h expected f31474a9", d); else passed++;
  endtask

  task automatic test_registered;
    logic [31:0] d;
    sel = 1'b1;
    sweep($urandom, $urandom, 16'hFFFF, -1);
    checks++; if (r_cyc !== 49) $display("FAIL reg_done_cycle: got %0d expected 49", r_cyc); else passed++;
    checks++; if (r_err !== 0) $display("FAIL reg_control_stable: got %0d bad cycles expected 0", r_err); else passed++;
    checks++; if (valid_w !== 16'hFFFF) $display("FAIL reg_valid: got %h expected ffff", valid_w); else passed++;
    for (int i = 0; i < 16; i++) begin
      rd(i, d);
      checks++; if (d !== exp_buf[1][i]) $display("FAIL reg_entry%0d: got %h expected %h", i, d, exp_buf[1][i]); else passed++;
    end
    sel = 1'b0;
  endtask

  task automatic test_busy_start;
    logic [31:0] d;
    logic [15:0] m;
    int n0;
    int bad = 0;
    sel = 1'b0;
    m = 16'($urandom) | 16'h0001;
    n0 = dc0;
    sweep($urandom, $urandom, m, 5);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (r_cyc !== exp_cycles(m, 0)) $display("FAIL busy_done_cycle: got %0d expected %0d", r_cyc, exp_cycles(m, 0)); else passed++;
    checks++; if (r_err !== 0) $display("FAIL busy_operands_held: got %0d bad cycles expected 0", r_err); else passed++;
    checks++; if (dc0 - n0 !== 1) $display("FAIL busy_done_pulses: got %0d expected 1", dc0 - n0); else passed++;
    checks++; if (valid_w !== m) $display("FAIL busy_valid: got %h expected %h", valid_w, m); else passed++;
    for (int i = 0; i < 16; i++) begin
      rd(i, d);
      if (d !== exp_buf[0][i]) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL busy_entries: got %0d wrong entries expected 0", bad); else passed++;
  endtask

  task automatic test_empty;
    logic [31:0] d;
    int bad = 0;
    int n0;
    sel = 1'b0;
    n0 = dc0;
    sweep($urandom, $urandom, 16'h0, -1);
    checks++; if (r_cyc !== 17) $display("FAIL empty_done_cycle: got %0d expected 17", r_cyc); else passed++;
    checks++; if (valid_w !== 16'h0) $display("FAIL empty_valid: got %h expected 0000", valid_w); else passed++;
    checks++; if (dc0 - n0 !== 1) $display("FAIL empty_done_pulses: got %0d expected 1", dc0 - n0); else passed++;
    for (int i = 0; i < 16; i++) begin
      rd(i, d);
      if (d !== exp_buf[0][i]) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL empty_buffer_kept: got %0d changed entries expected 0", bad); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] d;
    logic [15:0] m;
    int bad;
    for (int k = 0; k < 6; k++) begin
      sel = k[0];
      m = 16'($urandom);
      sweep($urandom, $urandom, m, -1);
      checks++; if (r_cyc !== exp_cycles(m, sel ? 2 : 0)) $display("FAIL rand%0d_done_cycle: got %0d expected %0d", k, r_cyc, exp_cycles(m, sel ? 2 : 0)); else passed++;
      checks++; if (r_err !== 0) $display("FAIL rand%0d_drive: got %0d bad cycles expected 0", k, r_err); else passed++;
      checks++; if (valid_w !== exp_valid[sel]) $display("FAIL rand%0d_valid: got %h expected %h", k, valid_w, exp_valid[sel]); else passed++;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        rd(i, d);
        if (d !== exp_buf[sel][i]) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL rand%0d_entries: got %0d wrong entries expected 0", k, bad); else passed++;
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int bad = 0;
    int n0;
    sel = 1'b0;
    n0 = dc0;
    op_a = $urandom;
    op_b = $urandom;
    op_mask = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    checks++; if (ctl_w !== 4'd7) $display("FAIL mid_idx_before_reset: got %0d expected 7", ctl_w); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({busy_w, done_w} !== 2'b00) $display("FAIL mid_busy_done: got busy=%b done=%b expected 0 0", busy_w, done_w); else passed++;
    checks++; if (valid_w !== 16'h0) $display("FAIL mid_valid: got %h expected 0000", valid_w); else passed++;
    checks++; if ({d1_w, d2_w, ctl_w} !== '0) $display("FAIL mid_alu_drive: got d1=%h d2=%h ctl=%h expected 0", d1_w, d2_w, ctl_w); else passed++;
    for (int i = 0; i < 16; i++) begin
      rd(i, d);
      if (d !== 32'h0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL mid_buffer_cleared: got %0d nonzero entries expected 0", bad); else passed++;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (dc0 - n0 !== 0) $display("FAIL mid_no_done: got %0d pulses expected 0", dc0 - n0); else passed++;
  endtask

  initial begin
    test_reset();
    test_comb();
    test_partial();
    test_registered();
    test_busy_start();
    test_empty();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator-side companion to the 32-bit ALU. It drives the ALU's d1/d2/control inputs through a programmable sweep of the 16 control codes, then captures each result into an internal 16x32 result buffer.
- Used for built-in self-test and for bring-up sweeps of the execute stage. A start/busy/done handshake controls it, and a registered read port reads the buffer back.

Parameters:
- ALU_LAT, 0, ALU result latency in cycles: 0 means combinational, 1..3 means registered/pipelined ALU.
- WIDTH, 32, operand and result width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- op_a  input  WIDTH  operand A, latched on accepted start
- op_b  input  WIDTH  operand B, latched on accepted start
- op_mask  input  16  bit i=1 means run control code i; latched on accepted start
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when the sweep completes
- alu_d1  output  WIDTH  to ALU d1
- alu_d2  output  WIDTH  to ALU d2
- alu_control  output  4  to ALU control
- alu_result  input  WIDTH  from ALU result
- rd_idx  input  4  result buffer read index
- rd_data  output  WIDTH  buffer[rd_idx], registered, 1-cycle latency
- valid_mask  output  16  bit i set means buffer[i] was written in the last sweep

Behaviour:
- Reset, state IDLE. Outputs on reset:
  - busy=0, done=0
  - alu_d1=0, alu_d2=0, alu_control=0
  - rd_data=0, valid_mask=0
  - all buffer entries 0
- IDLE:
  - On start=1, latch op_a/op_b/op_mask, set idx=0, clear valid_mask, go to ISSUE.
  - busy rises the cycle after start is sampled.
  - start while busy is ignored; no queueing.
- ISSUE:
  - Drive alu_d1=A, alu_d2=B, alu_control=idx.
  - Masked-off code (mask[idx]=0): no capture; spend 1 cycle, then advance.
  - Enabled code with ALU_LAT=0: capture alu_result into buffer[idx] at the end of this cycle, set valid_mask[idx], then advance.
  - Enabled code with ALU_LAT>0: go to WAIT with wait counter = ALU_LAT.
- WAIT:
  - alu_d1/alu_d2/alu_control are held stable.
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture alu_result in that cycle, set valid_mask[idx], then advance.
- Advance: if idx==15, go to DONE; else idx++ and go to ISSUE. idx never wraps during a sweep.
- DONE: done=1 for exactly one cycle, busy stays 1 in this cycle, then IDLE with busy=0.
- Sweep length in cycles, from first ISSUE through the end of the last capture: 16 + popcount(mask)*ALU_LAT.
  - ALU_LAT=0, full mask: 16 ISSUE cycles + 1 DONE cycle.
- Entries not enabled in a sweep keep their prior contents; valid_mask shows which entries are fresh.
- op_mask=0: sweep runs 16 cycles, captures nothing, still pulses done, valid_mask=0.
- Read port:
  - rd_data <= buffer[rd_idx] every cycle, including while busy.
  - Same-cycle write and read of the same index returns the OLD value; the new value appears one cycle later.
- After the sweep, alu_d1/alu_d2/alu_control hold their last driven values until the next start or reset.
- rst mid-sweep: immediate return to IDLE with all reset values. Buffer is cleared and no done pulse is produced.
- No arithmetic inside the block. Results are stored verbatim at WIDTH bits.

Decomposition:
- Shared package contents:
  - ALU control code constants (4-bit, 16 codes), reused by the ALU and decoder.
  - Sequencer state enum: IDLE, ISSUE, WAIT, DONE.
  - ALU_LAT_MAX=3 constant.
- One natural sub-module: alu_seq_rbuf, the 16xWIDTH result buffer with one write port and a registered read port, plus valid_mask tracking.

Test Plan:
- All stimulus uses bench ALU model result=d1+d2+control.
- Test 1, combinational ALU:
  - Stimulus: ALU_LAT=0, op_a=32'hF31474A1, op_b=32'h00000005, op_mask=16'hFFFF, start pulse.
  - Required: done exactly 17 cycles after start is sampled; valid_mask=16'hFFFF; rd_idx=3 gives 32'hF31474A9; rd_idx=15 gives 32'hF31474B5.
- Test 2, partial mask:
  - Stimulus: op_mask=16'h8001 after Test 1, op_a=0, op_b=0.
  - Required: buffer[0]=0, buffer[15]=32'h0000000F, buffer[3] still 32'hF31474A9, valid_mask=16'h8001.
- Test 3, registered ALU:
  - Stimulus: ALU_LAT=2 with a matching 2-stage model, full mask.
  - Required: done at cycle 16+32+1=49; alu_control held stable across each WAIT; all 16 entries correct.
- Test 4, start while busy:
  - Stimulus: start re-asserted with new operands during a sweep.
  - Required: ignored; results reflect the original operands; exactly one done pulse.
- Test 5, reset mid-sweep:
  - Stimulus: rst for 1 cycle at idx=7.
  - Required: busy=0 next cycle, valid_mask=0, every rd_idx reads 0, no done pulse.
- Test 6, empty mask:
  - Stimulus: op_mask=0.
  - Required: done at cycle 17, valid_mask=0, buffer unchanged.
